// File: rtl/sram_pkg.sv
// Shared constants and helpers for the serial-load SRAM macro behavioural model.
package sram_pkg;

   // Default geometry: address width and word width in bits
   localparam int unsigned SRAM_ROWS_DEF = 2;
   localparam int unsigned SRAM_COLS_DEF = 1;

   // Number of words addressable with a given address width
   function automatic int unsigned sram_depth(input int unsigned rows);
      return 32'(1) << rows;
   endfunction

endpackage : sram_pkg

// File: rtl/sram_shift_reg.sv
// Serial-in write-data register for the SRAM macro.
// Optional build macro SRAM_SCAN_OUT_EN adds a serial_out tap (MSB of the
// register) so several macros can be daisy-chained on one serial line.
module sram_shift_reg
   import sram_pkg::*;
#(
   parameter int unsigned COLS = SRAM_COLS_DEF
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            serial_in,
   input  logic            shift,
`ifdef SRAM_SCAN_OUT_EN
   output logic            serial_out,
`endif
   output logic [COLS-1:0] sreg
);

   logic [COLS-1:0] sreg_nxt;

   // Next register value when shifting: new bit enters at the LSB
   generate
      if (COLS == 1) begin : g_one_bit
         always_comb begin
            sreg_nxt = serial_in;
         end
      end else begin : g_multi_bit
         always_comb begin
            sreg_nxt = {sreg[COLS-2:0], serial_in};
         end
      end
   endgenerate

   // Input register: clears on reset, shifts when enabled, otherwise holds
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         sreg <= '0;
      end else if (shift) begin
         sreg <= sreg_nxt;
      end
   end

`ifdef SRAM_SCAN_OUT_EN
   // Scan tap taken straight from the register MSB
   assign serial_out = sreg[COLS-1];
`endif

endmodule : sram_shift_reg

// File: rtl/sram_top.sv
// Behavioural top of a small SRAM macro with a serial-load write data path.
// Write data is shifted into a COLS-bit register and committed to mem[addr]
// on w_en; r_en reads mem[addr] to data_out with a one-cycle valid strobe.
// A write and read in the same cycle: the write wins, the read is dropped.
// Optional build macro SRAM_SCAN_OUT_EN exposes the register MSB on serial_out.
module sram_top
   import sram_pkg::*;
#(
   parameter int unsigned ROWS = SRAM_ROWS_DEF,
   parameter int unsigned COLS = SRAM_COLS_DEF
) (
   input  logic            clk,
   input  logic            arst_n,
   input  logic            serial_in,
   input  logic            shift,
   input  logic            w_en,
   input  logic            r_en,
   input  logic [ROWS-1:0] addr,
`ifdef SRAM_SCAN_OUT_EN
   output logic            serial_out,
`endif
   output logic [COLS-1:0] data_out,
   output logic            data_valid
);

   localparam int unsigned DEPTH = sram_depth(ROWS);

   logic [COLS-1:0] sreg;
   logic [COLS-1:0] mem [DEPTH];
   logic            rd_accept_c;

   // Serial write-data register
   sram_shift_reg #(
      .COLS       (COLS)
   ) u_shift_reg (
      .clk        (clk),
      .arst_n     (arst_n),
      .serial_in  (serial_in),
      .shift      (shift),
`ifdef SRAM_SCAN_OUT_EN
      .serial_out (serial_out),
`endif
      .sreg       (sreg)
   );

   // A read is only taken when no write competes for the array
   always_comb begin
      rd_accept_c = r_en && !w_en;
   end

   // Storage array: every word clears on reset; writes take the pre-edge register
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (w_en) begin
         mem[addr] <= sreg;
      end
   end

   // Read port: data_out holds until the next accepted read, valid pulses once
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= rd_accept_c;
         if (rd_accept_c) begin
            data_out <= mem[addr];
         end
      end
   end

endmodule : sram_top

// File: tb/tb_sram_top.sv
// Directed self-checking bench for sram_top: one 4-bit-word instance (a_*)
// and one default-geometry instance (b_*, ROWS=2 COLS=1).
// Build with SRAM_SCAN_OUT_EN defined to also check the serial_out tap.
`timescale 1ns/1ps
module tb_sram_top;

   logic       clk;
   logic       arst_n;

   logic       a_sin, a_shift, a_wen, a_ren;
   logic [1:0] a_addr;
   logic [3:0] a_dout;
   logic       a_dv;

   logic       b_sin, b_shift, b_wen, b_ren;
   logic [1:0] b_addr;
   logic [0:0] b_dout;
   logic       b_dv;

`ifdef SRAM_SCAN_OUT_EN
   logic       a_sout;
   logic       b_sout;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   sram_top #(.ROWS(2), .COLS(4)) u_dut_a (
      .clk        (clk),
      .arst_n     (arst_n),
      .serial_in  (a_sin),
      .shift      (a_shift),
      .w_en       (a_wen),
      .r_en       (a_ren),
      .addr       (a_addr),
`ifdef SRAM_SCAN_OUT_EN
      .serial_out (a_sout),
`endif
      .data_out   (a_dout),
      .data_valid (a_dv)
   );

   sram_top u_dut_b (
      .clk        (clk),
      .arst_n     (arst_n),
      .serial_in  (b_sin),
      .shift      (b_shift),
      .w_en       (b_wen),
      .r_en       (b_ren),
      .addr       (b_addr),
`ifdef SRAM_SCAN_OUT_EN
      .serial_out (b_sout),
`endif
      .data_out   (b_dout),
      .data_valid (b_dv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Advance one clock; outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_drive(input logic sh, input logic si, input logic w, input logic r, input logic [1:0] ad);
      a_shift = sh; a_sin = si; a_wen = w; a_ren = r; a_addr = ad;
      tick();
   endtask

   task automatic b_drive(input logic sh, input logic si, input logic w, input logic r, input logic [1:0] ad);
      b_shift = sh; b_sin = si; b_wen = w; b_ren = r; b_addr = ad;
      tick();
   endtask

   initial begin
      arst_n = 1'b0;
      a_sin = 0; a_shift = 0; a_wen = 1; a_ren = 1; a_addr = 0;
      b_sin = 0; b_shift = 0; b_wen = 1; b_ren = 1; b_addr = 0;
      // Reset held for two cycles with both strobes active
      tick();
      tick();
      check("rst_a_dout", 32'(a_dout), 32'h0);
      check("rst_a_dv",   32'(a_dv),   32'h0);
      check("rst_b_dout", 32'(b_dout), 32'h0);
      check("rst_b_dv",   32'(b_dv),   32'h0);
      a_wen = 0; a_ren = 0; b_wen = 0; b_ren = 0;
      arst_n = 1'b1;
      tick();

      // Every address of A reads 0 after reset
      for (int i = 0; i < 4; i++) begin
         a_drive(0, 0, 0, 1, 2'(i));
         check($sformatf("rst_rd_a%0d", i), 32'(a_dout), 32'h0);
         check($sformatf("rst_rd_a%0d_dv", i), 32'(a_dv), 32'h1);
      end
      a_drive(0, 0, 0, 0, 0);
      check("a_dv_idle", 32'(a_dv), 32'h0);

      // B: shift in a 1, write addr 0, read it back
      b_drive(1, 1, 0, 0, 0);
      b_drive(0, 0, 1, 0, 0);
      b_drive(0, 0, 0, 1, 0);
      check("b_rd0", 32'(b_dout), 32'h1);
      check("b_rd0_dv", 32'(b_dv), 32'h1);
      b_drive(0, 0, 0, 0, 0);
      check("b_dv_one_cycle", 32'(b_dv), 32'h0);
      check("b_dout_hold", 32'(b_dout), 32'h1);
      b_drive(0, 0, 0, 1, 1);
      check("b_rd1", 32'(b_dout), 32'h0);
      b_drive(0, 0, 0, 1, 0);
      check("b_rd0_again", 32'(b_dout), 32'h1);

      // B: simultaneous write and read at addr 1 with sreg=1
      b_drive(0, 0, 1, 1, 1);
      check("b_wr_rd_dv", 32'(b_dv), 32'h0);
      check("b_wr_rd_hold", 32'(b_dout), 32'h1);
      b_drive(0, 0, 0, 1, 1);
      check("b_rd1_after_wr", 32'(b_dout), 32'h1);

      // B: write with a concurrent shift stores the old register value
      b_drive(1, 0, 0, 0, 0);
      b_drive(1, 1, 1, 0, 2);
      b_drive(0, 0, 0, 1, 2);
      check("b_wr_shift_old", 32'(b_dout), 32'h0);
      b_drive(0, 0, 1, 0, 3);
      b_drive(0, 0, 0, 1, 3);
      check("b_sreg_shifted", 32'(b_dout), 32'h1);

      // A: shift 1,0,1,1 -> 4'b1011, write addr 3, read addr 3 then addr 2
      a_drive(1, 1, 0, 0, 0);
      a_drive(1, 0, 0, 0, 0);
      a_drive(1, 1, 0, 0, 0);
      a_drive(1, 1, 0, 0, 0);
      a_drive(0, 0, 1, 0, 3);
      a_drive(0, 0, 0, 1, 3);
      check("a_rd3", 32'(a_dout), 32'hB);
      check("a_rd3_dv", 32'(a_dv), 32'h1);
      a_drive(0, 0, 0, 1, 2);
      check("a_rd2", 32'(a_dout), 32'h0);
      check("a_rd2_dv", 32'(a_dv), 32'h1);

      // A: shift 1,0,0,0 -> 4'b1000; scan tap shows MSB
      a_drive(1, 1, 0, 0, 0);
      a_drive(1, 0, 0, 0, 0);
      a_drive(1, 0, 0, 0, 0);
      a_drive(1, 0, 0, 0, 0);
`ifdef SRAM_SCAN_OUT_EN
      check("a_sout_4th", 32'(a_sout), 32'h1);
`endif
      a_drive(0, 0, 1, 0, 1);
      a_drive(0, 0, 0, 1, 1);
      check("a_rd1_8", 32'(a_dout), 32'h8);
      a_drive(1, 0, 0, 0, 0);
`ifdef SRAM_SCAN_OUT_EN
      check("a_sout_5th", 32'(a_sout), 32'h0);
`endif
      a_drive(0, 0, 0, 0, 0);

      // Reset pulsed mid-write: outputs clear at once, array wiped
      a_shift = 0; a_wen = 1; a_addr = 0;
      b_shift = 0; b_wen = 1; b_addr = 0;
      #2;
      arst_n = 1'b0;
      #1;
      check("midrst_a_dout", 32'(a_dout), 32'h0);
      check("midrst_b_dout", 32'(b_dout), 32'h0);
      tick();
      a_wen = 0; b_wen = 0;
      arst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         a_drive(0, 0, 0, 1, 2'(i));
         check($sformatf("post_rst_a%0d", i), 32'(a_dout), 32'h0);
         b_drive(0, 0, 0, 1, 2'(i));
         check($sformatf("post_rst_b%0d", i), 32'(b_dout), 32'h0);
      end
      // Register was cleared too: writing it stores 0
      a_drive(0, 0, 1, 0, 3);
      a_drive(0, 0, 0, 1, 3);
      check("post_rst_sreg_a", 32'(a_dout), 32'h0);
      b_drive(0, 0, 1, 0, 3);
      b_drive(0, 0, 0, 1, 3);
      check("post_rst_sreg_b", 32'(b_dout), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_sram_top
